roc_aer_decoder: RTL and testbench
==================================

// Module: roc_aer_decoder
// PURPOSE
//  Receive side of the 10-bit AER link carrying rank-order-coded (ROC) pixel indices.
//  - Completes a 4-phase REQ/ACK handshake per event.
//  - Detects the two-event frame-start marker and rebuilds an intensity image from
//    arrival order: earlier index = brighter pixel.
//  - Sits between the AER link and a downstream image consumer (checker, host readback).
// PARAMETERS
//  IMAGE_SIZE       256                        pixels per frame; must be <= 256
//  IMAGE_SIZE_BITS  $clog2(IMAGE_SIZE)         pixel index width
//  PIXEL_MAX_VALUE  255                        intensity given to rank 0
//  PIXEL_BITS       $clog2(PIXEL_MAX_VALUE+1)  pixel width
//  MARKER_ADDR      10'h1FF                    frame-start marker ({1'b0,1'b1,8'hFF})
// PORTS
//  CLK          in   1           clock
//  RST          in   1           reset, asynchronous, active-high
//  AER_ADDR     in   10          event address; stable while AER_REQ is high
//  AER_REQ      in   1           request; asynchronous to CLK
//  AER_ACK      out  1           acknowledge
//  FLUSH        in   1           1-cycle pulse: end the current frame early
//  IMAGE        out  PIXEL_BITS  [0:IMAGE_SIZE-1] reconstructed image, registered
//  IMAGE_VALID  out  1           1-cycle pulse: IMAGE holds a complete frame
//  DECODER_BUSY out  1           high while a frame is open (ARM or RECV)
//  RANK         out  IMAGE_SIZE_BITS+1  count of unique indices accepted in this frame
// BEHAVIOUR
//  Reset: AER_ACK=0, IMAGE all 0, IMAGE_VALID=0, DECODER_BUSY=0, RANK=0, state=IDLE.
//  - RST mid-frame aborts the frame. Handshake restarts cleanly once REQ is seen low.
//  Handshake (sub-module):
//  - AER_REQ passes through a 2-FF synchronizer.
//  - On a synchronized rising REQ, AER_ADDR is latched and `ev_valid` pulses for one cycle.
//  - AER_ACK rises in the cycle after that capture.
//  - AER_ACK falls one cycle after the synchronized REQ is seen low.
//  - A new event is never accepted while AER_ACK is high.
//  - Worst-case latency REQ-rise to ACK-rise: 4 CLK.
//  Event classes:
//  - MARK: addr == MARKER_ADDR.
//  - PIX: addr[9:8] == 2'b00 and addr[7:0] < IMAGE_SIZE.
//  - BAD: anything else. BAD is always dropped and has no state effect.
//  FSM:
//  - IDLE: MARK -> ARM. Everything else is dropped.
//  - ARM:  MARK -> RECV; on entry clear the written-bitmap, RANK, and IMAGE shadow to 0.
//          PIX -> IDLE, event dropped.
//  - RECV, PIX with index i:
//    - If written[i]==0: shadow[i] = (RANK < PIXEL_MAX_VALUE) ? PIXEL_MAX_VALUE-RANK : 0
//      (saturating); written[i]=1; RANK++.
//    - If written[i]==1 (duplicate): ignored, RANK unchanged.
//  - RECV, MARK -> ARM: frame aborted, no IMAGE_VALID.
//  - RECV -> DONE when RANK reaches IMAGE_SIZE, or on FLUSH.
//  - If FLUSH and the final PIX arrive in the same cycle, the PIX is applied first, then DONE.
//  - DONE (1 cycle): copy shadow to IMAGE (unwritten pixels = 0); IMAGE_VALID=1; -> IDLE.
//  - FLUSH outside RECV is ignored.
//  - IMAGE changes only in DONE and holds its value until the next DONE.
//  DECODER_BUSY = (state==ARM || state==RECV).
// CONFIGURATION
//  ROC_DEC_ERR_STATS_EN defined: adds output ERR_BAD [7:0] and output ERR_DUP [7:0].
//  - Both are saturating counters of BAD events and duplicate PIX events.
//  - Both clear on RST and on ARM->RECV.
//  Undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package roc_pkg:
//  - roc_dec_state_t enum {IDLE, ARM, RECV, DONE}
//  - AER_MARKER constant 10'h1FF
//  - aer_ev_t enum {EV_MARK, EV_PIX, EV_BAD}
//  Sub-module aer_rx_4phase:
//  - contains the REQ synchronizer, the ADDR latch, and ACK generation
//  - outputs ev_valid and ev_addr
//  Top level holds the FSM, RANK, bitmap, shadow and IMAGE registers.
// TESTING
//  1. MARK,MARK, then PIX 5,9,0 then FLUSH -> IMAGE[5]=255, [9]=254, [0]=253, others 0;
//     IMAGE_VALID pulses once.
//  2. MARK,MARK, then all 256 indices in order 255..0 -> IMAGE[255-k]=255-k for k<=254,
//     IMAGE[0]=0; IMAGE_VALID the cycle after the last handshake; RANK=256.
//  3. MARK,MARK, PIX 7, PIX 7, PIX 3, FLUSH -> IMAGE[7]=255, IMAGE[3]=254, RANK=2,
//     ERR_DUP=1 (with _EN).
//  4. MARK,PIX 4 (no second MARK) -> IDLE, no frame;
//     then MARK,MARK,PIX 4,FLUSH -> IMAGE[4]=255.
//  5. Mid-frame MARK,MARK after 10 PIX -> no IMAGE_VALID, RANK=0, previous IMAGE unchanged;
//     addr 10'h2AA -> dropped, ERR_BAD=1.
//  6. Handshake: REQ high for 20 cycles -> exactly one event; ACK rises <=4 CLK after REQ;
//     ACK falls <=3 CLK after REQ falls; RST mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/roc_pkg.sv
// roc_pkg: shared types and constants for the ROC AER receive path.
package roc_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RECV, DONE} roc_dec_state_t;
    typedef enum logic [1:0] {EV_MARK, EV_PIX, EV_BAD} aer_ev_t;

    localparam logic [9:0] AER_MARKER = 10'h1FF;

    function automatic aer_ev_t aer_classify(input logic [9:0] addr, input logic [9:0] marker,
                                             input int image_size);
        return (addr == marker) ? EV_MARK :
               (addr[9:8] == 2'b00 && int'(addr[7:0]) < image_size) ? EV_PIX : EV_BAD;
    endfunction

endpackage

// File: rtl/aer_rx_4phase.sv
// aer_rx_4phase: 4-phase AER receiver; synchronizes REQ, latches ADDR, drives ACK.
module aer_rx_4phase (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] AER_ADDR,
    input  logic       AER_REQ,
    output logic       AER_ACK,
    output logic       ev_valid,
    output logic [9:0] ev_addr
);

    logic       req_meta_q, req_sync_q, armed_q, ack_q, ev_valid_q;
    logic       armed_d, ack_d, capture;
    logic [9:0] addr_q;

    assign capture = req_sync_q && armed_q && !ack_q;

    always_comb begin
        armed_d = capture ? 1'b0 : (!req_sync_q ? 1'b1 : armed_q);
        ack_d   = ev_valid_q || (ack_q && req_sync_q);
    end

    // Synchronizer resets high so a REQ still asserted across reset is not taken as a new event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_meta_q <= 1'b1;
            req_sync_q <= 1'b1;
            armed_q    <= 1'b0;
            ack_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            req_meta_q <= AER_REQ;
            req_sync_q <= req_meta_q;
            armed_q    <= armed_d;
            ack_q      <= ack_d;
            ev_valid_q <= capture;
            if (capture) addr_q <= AER_ADDR;
        end
    end

    assign AER_ACK  = ack_q;
    assign ev_valid = ev_valid_q;
    assign ev_addr  = addr_q;

endmodule

// File: rtl/roc_aer_decoder.sv
// roc_aer_decoder: rebuilds a rank-order-coded image from AER events (earlier = brighter).
// Optional ROC_DEC_ERR_STATS_EN adds saturating BAD/duplicate event counters.
module roc_aer_decoder import roc_pkg::*; #(
    parameter int         IMAGE_SIZE      = 256,
    parameter int         IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int         PIXEL_MAX_VALUE = 255,
    parameter int         PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
    parameter logic [9:0] MARKER_ADDR     = AER_MARKER
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [9:0]             AER_ADDR,
    input  logic                   AER_REQ,
    output logic                   AER_ACK,
    input  logic                   FLUSH,
    output logic [PIXEL_BITS-1:0]  IMAGE [0:IMAGE_SIZE-1],
    output logic                   IMAGE_VALID,
    output logic                   DECODER_BUSY,
    output logic [IMAGE_SIZE_BITS:0] RANK
`ifdef ROC_DEC_ERR_STATS_EN
    ,
    output logic [7:0]             ERR_BAD,
    output logic [7:0]             ERR_DUP
`endif
);

    logic                      ev_valid;
    logic [9:0]                ev_addr;
    roc_dec_state_t            state_q, state_d;
    aer_ev_t                   ev_cls;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic [IMAGE_SIZE-1:0]     written_q;
    logic [PIXEL_BITS-1:0]     shadow_q [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0]     image_q [IMAGE_SIZE];
    logic [IMAGE_SIZE_BITS:0]  rank_q, rank_d;
    logic [PIXEL_BITS-1:0]     pix_val;
    logic                      valid_q, is_mark, is_pix, frame_start, pix_new, rank_full;

    aer_rx_4phase u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .AER_ADDR (AER_ADDR),
        .AER_REQ  (AER_REQ),
        .AER_ACK  (AER_ACK),
        .ev_valid (ev_valid),
        .ev_addr  (ev_addr)
    );

    assign ev_cls      = aer_classify(ev_addr, MARKER_ADDR, IMAGE_SIZE);
    assign idx         = ev_addr[IMAGE_SIZE_BITS-1:0];
    assign is_mark     = ev_valid && ev_cls == EV_MARK;
    assign is_pix      = ev_valid && ev_cls == EV_PIX;
    assign frame_start = state_q == ARM && is_mark;
    assign pix_new     = state_q == RECV && is_pix && !written_q[idx];
    assign rank_d      = rank_q + (IMAGE_SIZE_BITS+1)'(pix_new);
    assign rank_full   = rank_d == (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE);
    assign pix_val     = (int'(rank_q) < PIXEL_MAX_VALUE) ?
                         PIXEL_BITS'(PIXEL_MAX_VALUE - int'(rank_q)) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A PIX completing the frame is applied before FLUSH/full takes the FSM to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = is_mark ? ARM : IDLE;
            ARM:     state_d = is_mark ? RECV : (is_pix ? IDLE : ARM);
            RECV:    state_d = is_mark ? ARM : ((rank_full || FLUSH) ? DONE : RECV);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        DECODER_BUSY = state_q == ARM || state_q == RECV;
        IMAGE_VALID  = valid_q;
        RANK         = rank_q;
        IMAGE        = image_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            written_q <= '0;
            rank_q    <= '0;
            shadow_q  <= '{default: '0};
            image_q   <= '{default: '0};
            valid_q   <= 1'b0;
        end else begin
            valid_q <= state_q == DONE;
            if (state_q == DONE) image_q <= shadow_q;
            if (frame_start) begin
                written_q <= '0;
                rank_q    <= '0;
                shadow_q  <= '{default: '0};
            end else if (pix_new) begin
                written_q[idx] <= 1'b1;
                shadow_q[idx]  <= pix_val;
                rank_q         <= rank_d;
            end
        end
    end

`ifdef ROC_DEC_ERR_STATS_EN
    logic [7:0] err_bad_q, err_dup_q;
    logic       pix_dup;

    assign pix_dup = state_q == RECV && is_pix && written_q[idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST || frame_start) begin
            err_bad_q <= '0;
            err_dup_q <= '0;
        end else begin
            if (ev_valid && ev_cls == EV_BAD && err_bad_q != 8'hFF) err_bad_q <= err_bad_q + 8'd1;
            if (pix_dup && err_dup_q != 8'hFF) err_dup_q <= err_dup_q + 8'd1;
        end
    end

    assign ERR_BAD = err_bad_q;
    assign ERR_DUP = err_dup_q;
`endif

endmodule

// File: tb/tb_roc_aer_decoder.sv
// tb_roc_aer_decoder: randomized self-checking bench against a frame-level reference model.
module tb_roc_aer_decoder;

    logic       CLK = 1'b0, RST = 1'b1, AER_REQ = 1'b0, FLUSH = 1'b0;
    logic [9:0] AER_ADDR = '0;
    logic       AER_ACK, IMAGE_VALID, DECODER_BUSY;
    logic [7:0] image [0:255];
    logic [8:0] rank;
`ifdef ROC_DEC_ERR_STATS_EN
    logic [7:0] err_bad, err_dup;
`endif

    roc_aer_decoder dut (
        .CLK          (CLK),
        .RST          (RST),
        .AER_ADDR     (AER_ADDR),
        .AER_REQ      (AER_REQ),
        .AER_ACK      (AER_ACK),
        .FLUSH        (FLUSH),
        .IMAGE        (image),
        .IMAGE_VALID  (IMAGE_VALID),
        .DECODER_BUSY (DECODER_BUSY),
        .RANK         (rank)
`ifdef ROC_DEC_ERR_STATS_EN
        ,
        .ERR_BAD      (err_bad),
        .ERR_DUP      (err_dup)
`endif
    );

    always #5 CLK = ~CLK;

    localparam logic [9:0] MARK = 10'h1FF;

    int vectors = 0, miscompares = 0, valid_cnt = 0, ack_rises = 0;
    logic ack_prev = 1'b0;

    always @(negedge CLK) begin
        if (IMAGE_VALID) valid_cnt++;
        if (AER_ACK && !ack_prev) ack_rises++;
        ack_prev = AER_ACK;
    end

    // Reference model: frame phase 0=closed, 1=marker seen, 2=receiving.
    int m_phase, m_rank, m_valid, m_bad, m_dup;
    int m_shadow [256];
    int m_image [256];
    bit m_written [256];

    task automatic m_reset();
        m_phase = 0; m_rank = 0; m_valid = valid_cnt; m_bad = 0; m_dup = 0;
        for (int i = 0; i < 256; i++) begin
            m_shadow[i] = 0; m_image[i] = 0; m_written[i] = 0;
        end
    endtask

    task automatic m_finish();
        for (int i = 0; i < 256; i++) m_image[i] = m_shadow[i];
        m_valid++;
        m_phase = 0;
    endtask

    task automatic m_event(input logic [9:0] a);
        bit mark, pix;
        int i;
        mark = (a == MARK);
        pix  = (a[9:8] == 2'b00);
        i    = int'(a[7:0]);
        if (!mark && !pix) begin
            if (m_bad < 255) m_bad++;
            return;
        end
        case (m_phase)
            0: if (mark) m_phase = 1;
            1: if (mark) begin
                   m_phase = 2; m_rank = 0; m_bad = 0; m_dup = 0;
                   for (int k = 0; k < 256; k++) begin m_shadow[k] = 0; m_written[k] = 0; end
               end else m_phase = 0;
            default:
               if (mark) m_phase = 1;
               else if (m_written[i]) begin
                   if (m_dup < 255) m_dup++;
               end else begin
                   m_shadow[i] = (m_rank < 255) ? 255 - m_rank : 0;
                   m_written[i] = 1;
                   m_rank++;
                   if (m_rank == 256) m_finish();
               end
        endcase
    endtask

    function automatic int img_diff();
        for (int i = 0; i < 256; i++) if (image[i] !== 8'(m_image[i])) return i;
        return -1;
    endfunction

    task automatic send_event(input logic [9:0] a, input int hold);
        int lat;
        @(negedge CLK);
        AER_ADDR = a;
        AER_REQ  = 1'b1;
        lat = 0;
        while (!AER_ACK && lat < 12) begin @(negedge CLK); lat++; end
        vectors++;
        if (!AER_ACK || lat > 4) begin
            miscompares++;
            $display("FAIL ack_rise addr=%h: ack=%0b after %0d clk, want 1 within 4", a, AER_ACK, lat);
        end
        repeat (hold) @(negedge CLK);
        AER_REQ = 1'b0;
        lat = 0;
        while (AER_ACK && lat < 12) begin @(negedge CLK); lat++; end
        vectors++;
        if (AER_ACK || lat > 3) begin
            miscompares++;
            $display("FAIL ack_fall addr=%h: ack=%0b after %0d clk, want 0 within 3", a, AER_ACK, lat);
        end
        m_event(a);
    endtask

    task automatic do_flush();
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        if (m_phase == 2) m_finish();
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_frame(input string name);
        int d;
        d = img_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL %s image[%0d]: got %0d want %0d", name, d, image[d], m_image[d]);
        end
        vectors++;
        if (valid_cnt != m_valid) begin
            miscompares++;
            $display("FAIL %s valid_count: got %0d want %0d", name, valid_cnt, m_valid);
        end
        vectors++;
        if (rank !== 9'(m_rank) || DECODER_BUSY !== (m_phase != 0)) begin
            miscompares++;
            $display("FAIL %s rank/busy: got %0d/%0b want %0d/%0b", name, rank, DECODER_BUSY,
                     m_rank, m_phase != 0);
        end
`ifdef ROC_DEC_ERR_STATS_EN
        vectors++;
        if (err_bad !== 8'(m_bad) || err_dup !== 8'(m_dup)) begin
            miscompares++;
            $display("FAIL %s err_bad/err_dup: got %0d/%0d want %0d/%0d", name, err_bad, err_dup,
                     m_bad, m_dup);
        end
`endif
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        m_reset();
        vectors++;
        if (AER_ACK !== 1'b0 || IMAGE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset ack/valid: got %0b/%0b want 0/0", AER_ACK, IMAGE_VALID);
        end
        check_frame("reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_flush_frame();
        send_event(MARK, 0); send_event(MARK, 0);
        send_event(10'd5, 0); send_event(10'd9, 0); send_event(10'd0, 0);
        do_flush();
        vectors++;
        if (image[5] !== 8'd255 || image[9] !== 8'd254 || image[0] !== 8'd253) begin
            miscompares++;
            $display("FAIL flush_frame pixels 5/9/0: got %0d/%0d/%0d want 255/254/253",
                     image[5], image[9], image[0]);
        end
        check_frame("flush_frame");
    endtask

    task automatic test_full_frame();
        send_event(MARK, 0); send_event(MARK, 0);
        for (int k = 0; k < 256; k++) send_event(10'(255 - k), 0);
        vectors++;
        if (rank !== 9'd256 || image[0] !== 8'd0 || image[200] !== 8'd200) begin
            miscompares++;
            $display("FAIL full_frame rank/img0/img200: got %0d/%0d/%0d want 256/0/200",
                     rank, image[0], image[200]);
        end
        check_frame("full_frame");
    endtask

    task automatic test_duplicate();
        send_event(MARK, 0); send_event(MARK, 0);
        send_event(10'd7, 0); send_event(10'd7, 0); send_event(10'd3, 0);
        do_flush();
        vectors++;
        if (image[7] !== 8'd255 || image[3] !== 8'd254 || rank !== 9'd2) begin
            miscompares++;
            $display("FAIL duplicate img7/img3/rank: got %0d/%0d/%0d want 255/254/2",
                     image[7], image[3], rank);
        end
        check_frame("duplicate");
    endtask

    task automatic test_arm_abort();
        send_event(MARK, 0); send_event(10'd4, 0);
        vectors++;
        if (DECODER_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_abort busy: got %0b want 0", DECODER_BUSY);
        end
        do_flush();
        check_frame("flush_in_idle");
        send_event(MARK, 0); send_event(MARK, 0); send_event(10'd4, 0);
        do_flush();
        check_frame("arm_retry");
    endtask

    task automatic test_mid_abort();
        send_event(MARK, 0); send_event(MARK, 0);
        for (int k = 0; k < 10; k++) send_event(10'($urandom_range(0, 255)), 0);
        send_event(MARK, 0); send_event(MARK, 0);
        check_frame("mid_abort");
        send_event(10'h2AA, 0);
        check_frame("bad_event");
        do_flush();
        check_frame("after_abort");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            send_event(MARK, 0); send_event(MARK, 0);
            for (int n = $urandom_range(1, 40); n > 0; n--) begin
                if ($urandom_range(0, 9) == 0) send_event(10'h200 | 10'($urandom_range(0, 511)), 0);
                else send_event(10'($urandom_range(0, 63)), 0);
            end
            do_flush();
            check_frame("random_frame");
        end
    endtask

    task automatic test_random_stream();
        int r;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) send_event(MARK, 0);
            else if (r < 3) send_event(10'h200 | 10'($urandom_range(0, 511)), 0);
            else send_event(10'($urandom_range(0, 255)), 0);
            if ($urandom_range(0, 7) == 0) do_flush();
            check_frame("random_stream");
        end
    endtask

    task automatic test_handshake();
        int rises;
        rises = ack_rises;
        send_event(MARK, 20);
        repeat (2) @(negedge CLK);
        vectors++;
        if (ack_rises - rises != 1 || DECODER_BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL long_req ack_rises/busy: got %0d/%0b want 1/1", ack_rises - rises,
                     DECODER_BUSY);
        end
        send_event(MARK, 0);
        send_event(10'd42, 0);
        @(negedge CLK);
        AER_ADDR = MARK;
        AER_REQ  = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        m_reset();
        vectors++;
        if (AER_ACK !== 1'b0 || IMAGE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid ack/valid: got %0b/%0b want 0/0", AER_ACK, IMAGE_VALID);
        end
        check_frame("rst_mid");
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        vectors++;
        if (AER_ACK !== 1'b0 || DECODER_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_req ack/busy: got %0b/%0b want 0/0", AER_ACK, DECODER_BUSY);
        end
        AER_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        send_event(MARK, 0);
        check_frame("restart");
    endtask

    initial begin
        test_reset();
        test_flush_frame();
        test_full_frame();
        test_duplicate();
        test_arm_abort();
        test_mid_abort();
        test_random_frames();
        test_random_stream();
        test_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
